// File: rtl/instruction_fetch_controller.sv
// Fetches instructions from a combinational word-addressed memory into a 2-entry {PC, instr} buffer.
// Decode pops the buffer over valid/ready; a redirect flushes it and re-targets the PC.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic [31:0] o_address,
  input  logic [31:0] i_instruction,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_instr,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic [31:0] r_fetch_count;

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_next;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & i_out_ready;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign w_push  = i_enable & ~i_redirect & ((r_count != 2'd2) | w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_count       <= 2'd0;
      r_fetch_count <= 32'd0;
    end else if (i_redirect) begin
      r_pc    <= {i_redirect_pc[31:2], 2'b00};
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_next;
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push) begin
        r_tail        <= ~r_tail;
        r_pc          <= r_pc + 32'd4;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // Entry storage needs no reset: it is only observed while the occupancy count covers it.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_fifo_pc[r_tail]    <= r_pc;
      r_fifo_instr[r_tail] <= i_instruction;
    end
  end

  assign o_address     = r_pc;
  assign o_out_valid   = w_valid;
  assign o_out_instr   = w_valid ? r_fifo_instr[r_head] : 32'd0;
  assign o_out_pc      = w_valid ? r_fifo_pc[r_head]    : 32'd0;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, enable, redirect, ready;
  logic [31:0] rpc;
  bit          mem_mode;

  logic [31:0] addr, instr, out_instr, out_pc, fcount;
  logic        out_valid;
  logic [31:0] w_addr, w_instr, w_out_instr, w_out_pc, w_fcount;
  logic        w_out_valid;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode) return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign instr   = mem_mode ? ((addr * 32'h9E37_79B9) ^ 32'h1234_5678) : (32'h1000_0000 + (addr >> 2));
  assign w_instr = mem_mode ? ((w_addr * 32'h9E37_79B9) ^ 32'h1234_5678) : (32'h1000_0000 + (w_addr >> 2));

  instruction_fetch_controller dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .o_address(addr),
    .i_instruction(instr), .i_redirect(redirect), .i_redirect_pc(rpc),
    .o_out_valid(out_valid), .i_out_ready(ready), .o_out_instr(out_instr),
    .o_out_pc(out_pc), .o_fetch_count(fcount)
  );

  instruction_fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .o_address(w_addr),
    .i_instruction(w_instr), .i_redirect(redirect), .i_redirect_pc(rpc),
    .o_out_valid(w_out_valid), .i_out_ready(ready), .o_out_instr(w_out_instr),
    .o_out_pc(w_out_pc), .o_fetch_count(w_fcount)
  );

  // Reference model: a bounded queue of fetched {pc, instr}, a PC and a push counter.
  task automatic model_step();
    bit pop, push;
    pop  = (m_q.size() > 0) && ready;
    push = enable && !redirect && ((m_q.size() < 2) || pop);
    if (reset) begin
      m_q.delete();
      m_pc = 32'h0;
      m_fc = 32'h0;
    end else if (redirect) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
        m_fc = m_fc + 32'd1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic rd, input logic rr, input logic [31:0] p);
    reset = r; enable = e; redirect = rd; ready = rr; rpc = p;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if (fcount !== 32'h0) begin errors++; $display("FAIL reset_fcount got %h exp 0", fcount); end
  endtask

  task automatic test_stream();
    drive(0, 1, 0, 1, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1)) || out_instr !== 32'h1000_0000 + 32'(k - 1)) begin
        errors++;
        $display("FAIL stream_c%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", k, out_valid, out_pc, out_instr,
                 32'(4 * (k - 1)), 32'h1000_0000 + 32'(k - 1));
      end
    end
    checks++; if (fcount !== 32'd10) begin errors++; $display("FAIL stream_fcount got %0d exp 10", fcount); end
  endtask

  task automatic test_backpressure();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
        errors++; $display("FAIL bp_head_c%0d got v=%b pc=%h exp v=1 pc=0", k, out_valid, out_pc);
      end
    end
    checks++; if (addr !== 32'h8) begin errors++; $display("FAIL bp_addr got %h exp 8", addr); end
    checks++; if (fcount !== 32'd2) begin errors++; $display("FAIL bp_fcount got %0d exp 2", fcount); end
    ready = 1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * j)) begin
        errors++; $display("FAIL bp_drain_%0d got v=%b pc=%h exp v=1 pc=%h", j, out_valid, out_pc, 32'(4 * j));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 0, 32'h0);
    tick();
    tick();
    drive(0, 1, 1, 1, 32'h0000_0103);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", out_valid); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 100", addr); end
    checks++; if (fcount !== 32'd2) begin errors++; $display("FAIL redir_fcount got %0d exp 2", fcount); end
    redirect = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h1000_0040) begin
      errors++; $display("FAIL redir_first got v=%b pc=%h i=%h exp v=1 pc=100 i=10000040", out_valid, out_pc, out_instr);
    end
    tick();
    checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL redir_second got %h exp 104", out_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    drive(1, 0, 0, 0, 32'h0);
    tick();
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset_addr got %h exp fffffff8", w_addr); end
    drive(0, 1, 0, 1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (w_out_valid !== 1'b1 || w_out_pc !== exp_pc[k] || w_out_instr !== mem_word(exp_pc[k])) begin
        errors++; $display("FAIL wrap_%0d got v=%b pc=%h i=%h exp pc=%h i=%h", k, w_out_valid, w_out_pc,
                           w_out_instr, exp_pc[k], mem_word(exp_pc[k]));
      end
    end
  endtask

  task automatic test_enable_gating();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 0, 32'h0);
    tick();
    tick();
    drive(0, 0, 0, 1, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL gate_drain got v=%b pc=%h exp v=1 pc=4", out_valid, out_pc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || addr !== 32'h8 || fcount !== 32'd2) begin
        errors++; $display("FAIL gate_hold_%0d got v=%b a=%h fc=%0d exp v=0 a=8 fc=2", k, out_valid, addr, fcount);
      end
    end
    enable = 1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || addr !== 32'hC || fcount !== 32'd3) begin
      errors++; $display("FAIL gate_resume got v=%b pc=%h a=%h fc=%0d exp v=1 pc=8 a=c fc=3", out_valid, out_pc, addr, fcount);
    end
  endtask

  task automatic test_reset_priority();
    drive(0, 1, 0, 0, 32'h0);
    tick();
    tick();
    drive(1, 1, 1, 1, 32'h0000_0200);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || addr !== 32'h0 || fcount !== 32'h0) begin
      errors++; $display("FAIL rst_prio got v=%b i=%h pc=%h a=%h fc=%h exp all 0", out_valid, out_instr, out_pc, addr, fcount);
    end
    drive(0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] e_instr, e_pc;
    logic        e_valid;
    mem_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 9) < 8);
      ready    = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 29) == 0);
      rpc      = $urandom;
      tick();
      e_valid = (m_q.size() > 0);
      e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
      e_instr = e_valid ? m_q[0][31:0]  : 32'h0;
      checks++;
      if (out_valid !== e_valid || out_pc !== e_pc || out_instr !== e_instr) begin
        errors++; $display("FAIL rand_head_c%0d got v=%b pc=%h i=%h exp v=%b pc=%h i=%h", c, out_valid, out_pc,
                           out_instr, e_valid, e_pc, e_instr);
      end
      checks++;
      if (addr !== m_pc || fcount !== m_fc) begin
        errors++; $display("FAIL rand_state_c%0d got a=%h fc=%h exp a=%h fc=%h", c, addr, fcount, m_pc, m_fc);
      end
    end
  endtask

  initial begin
    mem_mode = 0;
    drive(1, 0, 0, 0, 32'h0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_enable_gating();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the combinational, word-addressed instruction memory on behalf of the decode stage. Owns the program counter, drives the memory address, and captures each returned instruction with its PC into a 2-entry fetch buffer. Presents fetched instructions to decode over a valid/ready handshake, and flushes and re-targets on branch/jump redirects. Sits between the instruction memory and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  1 = fetching permitted; 0 = no new pushes, and the buffer still drains.
- Address  out  32  memory address = current fetch PC; driven directly from the PC register.
- Instruction  in  32  memory read data for Address, valid in the same cycle (combinational memory).
- Redirect  in  1  1 = flush the buffer and load RedirectPC.
- RedirectPC  in  32  new fetch target; bits [1:0] forced to 0 on load.
- OutValid  out  1  buffer head holds a valid instruction.
- OutReady  in  1  decode accepts the head this cycle.
- OutInstr  out  32  instruction at the buffer head; 0 when OutValid = 0.
- OutPC  out  32  PC of OutInstr; 0 when OutValid = 0.
- FetchCount  out  32  number of pushes since reset; wraps modulo 2^32.

## Operation
- State: PC register, 2-entry FIFO of {PC, instruction} (head/tail pointers plus a 2-bit occupancy count 0..2), FetchCount.
- pop = OutValid & OutReady.
- push = Enable & ~Redirect & (count < 2 | pop).
- On push: FIFO tail <= {PC, Instruction}; PC <= PC + 4; FetchCount += 1.
- PC increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- On Redirect (highest priority): FIFO emptied (count <= 0); PC <= {RedirectPC[31:2], 2'b00}.
  - Any same-cycle pop is discarded and the entry is not counted as delivered.
  - No push that cycle; FetchCount is unchanged.
- With neither Redirect nor Reset, count next = count + push - pop.
- Push and pop in the same cycle at count = 2 is legal; count stays 2.
- Enable = 0: PC and FetchCount hold; pops continue normally.
- Outputs OutValid/OutInstr/OutPC come from the head entry (registered state), with no combinational path from OutReady.
- Reset (overrides Redirect and Enable): PC = RESET_PC, count = 0, pointers = 0, FetchCount = 0, OutValid = 0, OutInstr = 0, OutPC = 0, Address = RESET_PC.
  - A Reset asserted mid-stream discards all buffered entries.

## Timing
- Fetch latency: an instruction pushed at edge N is visible on OutValid/OutInstr at cycle N+1 (one cycle after its address was driven).
- Throughput: 1 instruction/cycle while OutReady is held 1.
- Buffer fills in 2 cycles when OutReady = 0.
- Redirect asserted in cycle N:
  - Address = RedirectPC at cycle N+1.
  - First redirected instruction OutValid at cycle N+2.
  - OutValid = 0 at cycle N+1.
- Handshake: once OutValid = 1, OutInstr/OutPC hold stable until pop, Redirect, or Reset.
- Address changes only on a push, Redirect, or Reset edge.

## Test plan
- Reset then stream: Reset 1 cycle, Enable = 1, OutReady = 1, memory word i = 32'h1000_0000 + i.
  - Cycle 1: OutPC = 0, OutInstr = 32'h1000_0000.
  - Each following cycle: OutPC += 4.
  - After 10 cycles: FetchCount = 10.
- Backpressure: OutReady = 0 for 5 cycles.
  - Count saturates at 2; Address holds at 8.
  - Head stays PC 0.
  - When OutReady = 1 again, delivery is PC 0, 4, 8 with no gaps and no duplicates.
- Redirect with pending pop: buffer holds PCs 0 and 4; assert Redirect with RedirectPC = 32'h0000_0103 and OutReady = 1.
  - Next cycle: OutValid = 0 and Address = 32'h100.
  - Cycle after: OutPC = 32'h100.
  - PC 4 is never delivered.
- Wrap-around: RESET_PC = 32'hFFFF_FFF8, stream 3 instructions → OutPC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Enable gating: drop Enable with 2 entries buffered and OutReady = 1.
  - Both entries drain, then OutValid = 0.
  - Address and FetchCount frozen until Enable returns.
- Reset priority: assert Reset together with Redirect and a full buffer.
  - Next cycle: all outputs are at reset values and Address = RESET_PC, not RedirectPC.
